// File: rtl/registro_pkg.sv
// Shared constants for the registro universal shift register:
// operation select codes and shift direction codes.
package registro_pkg;

   localparam logic [1:0] PUSH  = 2'b00;
   localparam logic [1:0] CYCLE = 2'b01;
   localparam logic [1:0] LOAD  = 2'b10;
   localparam logic [1:0] HOLD  = 2'b11;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/registro.sv
// Universal shift register: parallel load, serial push and rotate in either
// direction, with clock enable and a registered serial output.
module registro
   import registro_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENB,
   input  logic [1:0]       MODO,
   input  logic             DIR,
   input  logic             S_IN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             S_OUT
);

   logic [WIDTH-1:0] q_r;
   logic             s_out_r;
   logic [WIDTH-1:0] q_nxt_s;
   logic             s_out_nxt_s;

   // Next-state selection for the register word and the bit leaving it.
   always_comb begin
      q_nxt_s     = q_r;
      s_out_nxt_s = s_out_r;
      case (MODO)
         PUSH: begin
            if (DIR == LEFT) begin
               q_nxt_s     = {q_r[WIDTH-2:0], S_IN};
               s_out_nxt_s = q_r[WIDTH-1];
            end else begin
               q_nxt_s     = {S_IN, q_r[WIDTH-1:1]};
               s_out_nxt_s = q_r[0];
            end
         end
         CYCLE: begin
            if (DIR == LEFT) begin
               q_nxt_s     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
               s_out_nxt_s = q_r[WIDTH-1];
            end else begin
               q_nxt_s     = {q_r[0], q_r[WIDTH-1:1]};
               s_out_nxt_s = q_r[0];
            end
         end
         LOAD: begin
            q_nxt_s     = D;
            s_out_nxt_s = 1'b0;
         end
         default: begin
            q_nxt_s     = q_r;
            s_out_nxt_s = s_out_r;
         end
      endcase
   end

   // State register: reset wins over the enable; disabled cycles hold.
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_r     <= {WIDTH{1'b0}};
         s_out_r <= 1'b0;
      end else if (ENB) begin
         q_r     <= q_nxt_s;
         s_out_r <= s_out_nxt_s;
      end else begin
         q_r     <= q_r;
         s_out_r <= s_out_r;
      end
   end

   assign Q     = q_r;
   assign S_OUT = s_out_r;

endmodule

// File: tb/tb_registro.sv
// Directed self-checking bench for registro (WIDTH=32) with hand-computed
// expected values.
module tb_registro;
   import registro_pkg::*;

   localparam int WIDTH = 32;

   logic             CLK;
   logic             RST;
   logic             ENB;
   logic [1:0]       MODO;
   logic             DIR;
   logic             S_IN;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             S_OUT;

   int total = 0;
   int bad   = 0;

   registro #(.WIDTH(WIDTH)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .ENB  (ENB),
      .MODO (MODO),
      .DIR  (DIR),
      .S_IN (S_IN),
      .D    (D),
      .Q    (Q),
      .S_OUT(S_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] orig;

      RST  = 1'b1;
      ENB  = 1'b0;
      MODO = HOLD;
      DIR  = LEFT;
      S_IN = 1'b0;
      D    = 32'h0000_0000;

      // reset and hold
      tick(2);
      check("reset_q", Q, 32'h0000_0000);
      check("reset_sout", {31'd0, S_OUT}, 32'd0);

      RST  = 1'b0;
      ENB  = 1'b0;
      MODO = LOAD;
      D    = 32'hF09D_F09D;
      tick(3);
      check("enb0_hold_q", Q, 32'h0000_0000);

      // load then left push of zeros; original bits leave MSB first
      ENB = 1'b1;
      tick(1);
      check("load_q", Q, 32'hF09D_F09D);
      check("load_sout", {31'd0, S_OUT}, 32'd0);

      orig = 32'hF09D_F09D;
      MODO = PUSH;
      DIR  = LEFT;
      S_IN = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick(1);
         if (k == 0) check("push_left_1_q", Q, 32'hE13B_E13A);
         check("push_left_sout", {31'd0, S_OUT}, {31'd0, orig[31-k]});
      end
      check("push_left_32_q", Q, 32'h0000_0000);

      // right push fill with ones
      DIR  = RIGHT;
      S_IN = 1'b1;
      tick(1);
      check("push_right_1_q", Q, 32'h8000_0000);
      check("push_right_1_sout", {31'd0, S_OUT}, 32'd0);
      tick(31);
      check("push_right_32_q", Q, 32'hFFFF_FFFF);
      check("push_right_32_sout", {31'd0, S_OUT}, 32'd0);

      // rotate left
      MODO = LOAD;
      D    = 32'h82F9_505F;
      tick(1);
      check("rotl_load_q", Q, 32'h82F9_505F);
      MODO = CYCLE;
      DIR  = LEFT;
      tick(1);
      check("rotl_1_q", Q, 32'h05F2_A0BF);
      check("rotl_1_sout", {31'd0, S_OUT}, 32'd1);
      tick(31);
      check("rotl_32_q", Q, 32'h82F9_505F);
      check("rotl_32_sout", {31'd0, S_OUT}, 32'd1);

      // rotate right
      MODO = LOAD;
      D    = 32'hCAD6_F09D;
      tick(1);
      check("rotr_load_q", Q, 32'hCAD6_F09D);
      MODO = CYCLE;
      DIR  = RIGHT;
      tick(1);
      check("rotr_1_q", Q, 32'hE56B_784E);
      check("rotr_1_sout", {31'd0, S_OUT}, 32'd1);
      tick(31);
      check("rotr_32_q", Q, 32'hCAD6_F09D);
      check("rotr_32_sout", {31'd0, S_OUT}, 32'd1);

      // reset in the middle of a push sequence
      MODO = LOAD;
      D    = 32'hF09D_F09D;
      tick(1);
      MODO = PUSH;
      DIR  = LEFT;
      S_IN = 1'b1;
      tick(3);
      check("midpush_q", Q, 32'h84EF_84EF);
      check("midpush_sout", {31'd0, S_OUT}, 32'd1);
      RST = 1'b1;
      tick(1);
      check("midreset_q", Q, 32'h0000_0000);
      check("midreset_sout", {31'd0, S_OUT}, 32'd0);
      RST = 1'b0;

      // mode 11 holds with ENB=1
      MODO = LOAD;
      D    = 32'h8000_0001;
      tick(1);
      MODO = CYCLE;
      DIR  = LEFT;
      tick(1);
      check("pre_hold_q", Q, 32'h0000_0003);
      check("pre_hold_sout", {31'd0, S_OUT}, 32'd1);
      MODO = HOLD;
      S_IN = 1'b0;
      D    = 32'h1234_5678;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check("mode11_q", Q, 32'h0000_0003);
         check("mode11_sout", {31'd0, S_OUT}, 32'd1);
      end

      // ENB=0 holds a nonzero S_OUT while MODO asks for a push
      ENB  = 1'b0;
      MODO = PUSH;
      DIR  = RIGHT;
      tick(2);
      check("enb0_push_q", Q, 32'h0000_0003);
      check("enb0_push_sout", {31'd0, S_OUT}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/registro.md
Name: registro

Overview:
- Parameterised universal shift register: parallel load, serial shift (push) and rotate (cycle), direction selectable.
- Single clock domain with a clock enable and a registered serial output.
- Used as a generic datapath/serializer building block; default width 32 bits.

Parameters:
- WIDTH, 32, register word width in bits (>= 2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- ENB  input  1  clock enable; 1 = operate per MODO, 0 = hold Q and S_OUT.
- MODO  input  2  operation select: PUSH=2'b00, CYCLE=2'b01, LOAD=2'b10, 2'b11=hold.
- DIR  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
- S_IN  input  1  serial input bit, used in PUSH mode only.
- D  input  WIDTH  parallel load data, used in LOAD mode only.
- Q  output  WIDTH  register contents, registered.
- S_OUT  output  1  bit shifted or rotated out in the current cycle, registered.

Behaviour:
- Reset: on a rising CLK edge with RST=1, Q<=0 and S_OUT<=0. RST has priority over ENB and MODO. Reset mid-operation discards the operation in progress.
- ENB=0 (RST=0): Q and S_OUT hold, regardless of MODO, DIR, S_IN and D.
- ENB=1, all updates take effect one edge after the inputs are sampled (latency 1 cycle):
  - LOAD: Q<=D; S_OUT<=0.
  - PUSH, DIR=0: Q<={Q[WIDTH-2:0],S_IN}; S_OUT<=Q[WIDTH-1].
  - PUSH, DIR=1: Q<={S_IN,Q[WIDTH-1:1]}; S_OUT<=Q[0].
  - CYCLE, DIR=0: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; S_OUT<=Q[WIDTH-1].
  - CYCLE, DIR=1: Q<={Q[0],Q[WIDTH-1:1]}; S_OUT<=Q[0].
  - MODO=2'b11: Q and S_OUT hold.
- After WIDTH consecutive PUSH cycles, Q is filled entirely with the S_IN history; the original contents have exited via S_OUT in order.
- After WIDTH consecutive CYCLE cycles in one direction, Q equals its starting value.
- DIR and MODO may change on any cycle; each edge uses only the values sampled at that edge. No multicycle state and no FSM.
- Inputs are assumed synchronous to CLK. Unknown values on D matter only in LOAD mode.

Decomposition:
- Shared package/include holds the mode constants (PUSH, CYCLE, LOAD, HOLD, 2-bit) and the direction constants (LEFT=0, RIGHT=1). The bench uses the same constants.
- No sub-module: a single always block with a case on MODO.

Test Plan:
- Reset and hold: RST=1 for 2 edges -> Q=0, S_OUT=0. Then RST=0, ENB=0, MODO=LOAD, D=0xF09DF09D for 3 edges -> Q remains 0.
- Load, then left push: ENB=1, LOAD D=0xF09DF09D -> Q=0xF09DF09D next edge. Then PUSH, DIR=0, S_IN=0; after 1 edge Q=0xE13BE13A, S_OUT=1; after 32 edges Q=0x00000000.
- Right push fill: from Q=0, PUSH, DIR=1, S_IN=1; after 1 edge Q=0x80000000, S_OUT=0; after 32 edges Q=0xFFFFFFFF.
- Rotate left: LOAD 0x82F9505F, then CYCLE, DIR=0; after 1 edge Q=0x05F2A0BF, S_OUT=1; after 32 edges Q=0x82F9505F.
- Rotate right: LOAD 0xCAD6F09D, then CYCLE, DIR=1; after 1 edge Q=0xE56B784E, S_OUT=1; after 32 edges Q=0xCAD6F09D.
- Reset mid-shift and mode 11: during a PUSH sequence assert RST for one edge -> Q=0, S_OUT=0 that edge. Separately, with MODO=2'b11 and ENB=1, Q and S_OUT are unchanged over 4 edges.
